// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32 main control FSM and the ALU-control decoder:
// state encoding, opcodes, ALUOp codes, datapath mux select encodings and the control vector.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BEQ       = 4'd8,
        S_FAULT     = 4'd9
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // mem_wait marks states that touch memory and may have to stall on mem_ready
    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       mem_write;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
        logic       mem_wait;
    } ctrl_t;

    function automatic ctrl_t fetch_ctrl();
        ctrl_t f;
        f            = '0;
        f.adr_src    = 1'b0;
        f.ir_write   = 1'b1;
        f.src_a      = SRCA_PC;
        f.src_b      = SRCB_FOUR;
        f.alu_op     = ALUOP_ADD;
        f.result_src = RES_ALURESULT;
        f.pc_update  = 1'b1;
        f.mem_wait   = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/mc_state_decode.sv
// Purely combinational state -> control-vector decode for the multicycle main controller.
// Unreachable encodings decode to an all-zero vector so no enable fires.
module mc_state_decode
    import riscv_ctrl_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: ctrl = fetch_ctrl();
            S_DECODE: begin
                ctrl.src_a  = SRCA_OLDPC;
                ctrl.src_b  = SRCB_IMM;
                ctrl.alu_op = ALUOP_ADD;
            end
            S_MEM_ADR: begin
                ctrl.src_a  = SRCA_RS1;
                ctrl.src_b  = SRCB_IMM;
                ctrl.alu_op = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_wait   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                ctrl.mem_wait   = 1'b1;
            end
            S_EXECUTE_R: begin
                ctrl.src_a  = SRCA_RS1;
                ctrl.src_b  = SRCB_RS2;
                ctrl.alu_op = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl.src_a      = SRCA_RS1;
                ctrl.src_b      = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_FAULT: ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multicycle RV32 datapath (lw, sw, R-type, beq).
// Optional MEM_WAIT_EN adds a mem_ready input that stalls FETCH, MEM_READ and MEM_WRITE.
module multicycle_main_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
`ifdef MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal
);

`ifndef MEM_WAIT_EN
    logic mem_ready;
    assign mem_ready = 1'b1;
`endif

    state_e state_q, state_d;
    ctrl_t  dec_ctrl, ctrl;
    logic   mem_gate;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = S_EXECUTE_R;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FAULT;
                endcase
            end
            // opcode is re-sampled here; anything but lw/sw is treated as illegal
            S_MEM_ADR: begin
                if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE_R: state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BEQ:       state_d = S_FETCH;
            S_FAULT:     state_d = HALT_ON_ILLEGAL ? S_FAULT : S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    mc_state_decode u_decode (
        .state (state_q),
        .ctrl  (dec_ctrl)
    );

    // During reset the selects show FETCH values and every strobe is suppressed
    always_comb begin
        ctrl = dec_ctrl;
        if (reset) begin
            ctrl            = fetch_ctrl();
            ctrl.ir_write   = 1'b0;
            ctrl.pc_update  = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.reg_write  = 1'b0;
            ctrl.instr_done = 1'b0;
            ctrl.illegal    = 1'b0;
        end
    end

    assign mem_gate   = ~ctrl.mem_wait | mem_ready;

    assign alu_op     = ctrl.alu_op;
    assign alu_src_a  = ctrl.src_a;
    assign alu_src_b  = ctrl.src_b;
    assign result_src = ctrl.result_src;
    assign adr_src    = ctrl.adr_src;
    assign ir_write   = ctrl.ir_write & mem_gate;
    assign pc_write   = (ctrl.pc_update & mem_gate) | (ctrl.branch & zero);
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign instr_done = ctrl.instr_done & mem_gate;
    assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Randomized self-checking bench for multicycle_main_ctrl against a per-instruction phase model.
// Honors MEM_WAIT_EN when the build defines it.
module tb_multicycle_main_ctrl;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BEQ = 7'b1100011;

    logic       clk;
    logic       reset;
    logic       h_reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
    logic       adr_src, ir_write, pc_write, mem_write, reg_write, instr_done, illegal;
    logic [1:0] h_alu_op, h_alu_src_a, h_alu_src_b, h_result_src;
    logic       h_adr_src, h_ir_write, h_pc_write, h_mem_write, h_reg_write, h_instr_done, h_illegal;

    logic [14:0] got_m, got_h;
    assign got_m = {alu_op, alu_src_a, alu_src_b, result_src,
                    adr_src, ir_write, pc_write, mem_write, reg_write, instr_done, illegal};
    assign got_h = {h_alu_op, h_alu_src_a, h_alu_src_b, h_result_src,
                    h_adr_src, h_ir_write, h_pc_write, h_mem_write, h_reg_write, h_instr_done, h_illegal};

    int checks   = 0;
    int failures = 0;

    multicycle_main_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
`ifdef MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    multicycle_main_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
        .clk        (clk),
        .reset      (h_reset),
        .opcode     (opcode),
        .zero       (zero),
`ifdef MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .alu_op     (h_alu_op),
        .alu_src_a  (h_alu_src_a),
        .alu_src_b  (h_alu_src_b),
        .result_src (h_result_src),
        .adr_src    (h_adr_src),
        .ir_write   (h_ir_write),
        .pc_write   (h_pc_write),
        .mem_write  (h_mem_write),
        .reg_write  (h_reg_write),
        .instr_done (h_instr_done),
        .illegal    (h_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected output vector of one controller cycle, straight from the state/output table
    function automatic logic [14:0] exp_out(input string ph, input bit z, input bit rdy);
        logic [1:0] aop, sa, sb, rs;
        logic       adr, irw, pcw, mw, rw, dn, ill;
        aop = 2'b00; sa = 2'b00; sb = 2'b00; rs = 2'b00;
        adr = 0; irw = 0; pcw = 0; mw = 0; rw = 0; dn = 0; ill = 0;
        if (ph == "FETCH") begin
            sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy;
        end else if (ph == "RESET") begin
            sb = 2'b10; rs = 2'b10;
        end else if (ph == "DECODE") begin
            sa = 2'b01; sb = 2'b01;
        end else if (ph == "MEM_ADR") begin
            sa = 2'b10; sb = 2'b01;
        end else if (ph == "MEM_READ") begin
            adr = 1;
        end else if (ph == "MEM_WB") begin
            rs = 2'b01; rw = 1; dn = 1;
        end else if (ph == "MEM_WRITE") begin
            adr = 1; mw = 1; dn = rdy;
        end else if (ph == "EXECUTE_R") begin
            sa = 2'b10; aop = 2'b10;
        end else if (ph == "ALU_WB") begin
            rw = 1; dn = 1;
        end else if (ph == "BEQ") begin
            sa = 2'b10; aop = 2'b01; pcw = z; dn = 1;
        end else if (ph == "FAULT") begin
            ill = 1;
        end
        return {aop, sa, sb, rs, adr, irw, pcw, mw, rw, dn, ill};
    endfunction

    function automatic bit is_mem(input string ph);
        return (ph == "FETCH") || (ph == "MEM_READ") || (ph == "MEM_WRITE");
    endfunction

    // abort_at: phase index at which reset is raised; zf: forced zero (-1 random);
    // stall: ready=0 cycles per memory phase (-1 random)
    task automatic run_instr(input logic [6:0] opc, input int abort_at, input int zf, input int stall);
        string ph[$];
        int    cyc;
        cyc = 0;
        ph.push_back("FETCH");
        ph.push_back("DECODE");
        if (opc == LW) begin
            ph.push_back("MEM_ADR"); ph.push_back("MEM_READ"); ph.push_back("MEM_WB");
        end else if (opc == SW) begin
            ph.push_back("MEM_ADR"); ph.push_back("MEM_WRITE");
        end else if (opc == RT) begin
            ph.push_back("EXECUTE_R"); ph.push_back("ALU_WB");
        end else if (opc == BEQ) begin
            ph.push_back("BEQ");
        end else begin
            ph.push_back("FAULT");
        end
        for (int i = 0; i < ph.size(); i++) begin
            int tries;
            bit done;
            tries = 0;
            done  = 0;
            while (!done) begin
                @(posedge clk); #1;
                reset  = (i == abort_at);
                opcode = (ph[i] == "DECODE" || ph[i] == "MEM_ADR") ? opc : 7'($urandom);
                zero   = (zf < 0) ? 1'($urandom) : 1'(zf);
                if (!WAIT_EN)              mem_ready = 1'b1;
                else if (!is_mem(ph[i]))   mem_ready = 1'($urandom);
                else if (stall >= 0)       mem_ready = (tries >= stall);
                else                       mem_ready = (tries >= 3) || ($urandom_range(0, 3) != 0);
                @(negedge clk);
                cyc++;
                if (reset) begin
                    check_eq({ph[i], "_ABORT"}, 32'(got_m), 32'(exp_out("RESET", zero, mem_ready)));
                    $display("txn opc=%b aborted at %s cycles=%0d", opc, ph[i], cyc);
                    return;
                end
                check_eq(ph[i], 32'(got_m), 32'(exp_out(ph[i], zero, mem_ready)));
                done = !(WAIT_EN && is_mem(ph[i]) && !mem_ready);
                tries++;
            end
        end
        $display("txn opc=%b cycles=%0d", opc, cyc);
    endtask

    function automatic logic [6:0] pick_opcode();
        logic [6:0] o;
        case ($urandom_range(0, 4))
            0: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = BEQ;
            default: begin
                o = 7'($urandom);
                while (o == LW || o == SW || o == RT || o == BEQ) o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        reset     = 1'b1;
        h_reset   = 1'b1;
        opcode    = RT;
        zero      = 1'b0;
        mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            reset  = 1'b1;
            opcode = RT;
            @(negedge clk);
            check_eq("RESET_HOLD", 32'(got_m), 32'(exp_out("RESET", zero, mem_ready)));
        end

        run_instr(RT, -1, -1, 0);
        run_instr(LW, -1, -1, 0);
        run_instr(SW, -1, -1, 0);
        run_instr(BEQ, -1, 1, 0);
        run_instr(BEQ, -1, 0, 0);
        run_instr(7'b0010011, -1, -1, 0);
        run_instr(SW, 3, -1, 0);
        run_instr(RT, -1, -1, 0);
        if (WAIT_EN) run_instr(RT, -1, -1, 3);

        for (int n = 0; n < 60; n++) begin
            run_instr(pick_opcode(), -1, -1, -1);
        end

        // Halting instance: illegal must stick until reset
        @(posedge clk); #1;
        reset = 1'b1; h_reset = 1'b1;
        @(negedge clk);
        check_eq("H_RESET", 32'(got_h), 32'(exp_out("RESET", zero, mem_ready)));
        @(posedge clk); #1;
        h_reset = 1'b0; opcode = 7'($urandom); mem_ready = 1'b1;
        @(negedge clk);
        check_eq("H_FETCH", 32'(got_h), 32'(exp_out("FETCH", zero, 1'b1)));
        @(posedge clk); #1;
        opcode = 7'b0010011;
        @(negedge clk);
        check_eq("H_DECODE", 32'(got_h), 32'(exp_out("DECODE", zero, mem_ready)));
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            opcode    = 7'($urandom);
            zero      = 1'($urandom);
            mem_ready = WAIT_EN ? 1'($urandom) : 1'b1;
            @(negedge clk);
            check_eq("H_FAULT", 32'(got_h), 32'(exp_out("FAULT", zero, mem_ready)));
        end
        @(posedge clk); #1;
        h_reset = 1'b1;
        @(negedge clk);
        check_eq("H_RESET2", 32'(got_h), 32'(exp_out("RESET", zero, mem_ready)));
        @(posedge clk); #1;
        h_reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check_eq("H_RECOVER", 32'(got_h), 32'(exp_out("FETCH", zero, 1'b1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_main_ctrl.md
Name: multicycle_main_ctrl

Overview:
- Main control FSM for the multicycle RV32 datapath. Sits directly upstream of the ALU-control decoder and drives its 2-bit alu_op.
- Sequences lw, sw, R-type and beq through Fetch/Decode/Execute/Memory/Writeback.
- Drives all datapath mux selects and write enables.
- Flags illegal opcodes.

Parameters:
HALT_ON_ILLEGAL, 1, 1 = stay in FAULT until reset; 0 = return to FETCH after one FAULT cycle

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from the instruction register (valid from DECODE onward)
zero  in  1  ALU zero flag (combinational, same cycle)
alu_op  out  2  to ALU-control decoder: 00 add, 01 sub/compare, 10 funct-decoded
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 data
alu_src_b  out  2  00 rs2 data, 01 immediate, 10 constant 4
result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result
adr_src  out  1  0 PC, 1 ALUOut (memory address mux)
ir_write  out  1  load instruction register and OldPC
pc_write  out  1  pc_update OR (branch AND zero)
mem_write  out  1  data-memory write enable
reg_write  out  1  register-file write enable
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal  out  1  high while in FAULT

Behaviour:
- Moore FSM. State register updates on the rising edge of clk. Outputs decode combinationally from state only. Exception: pc_write also depends on zero in BEQ.
- Reset:
  - state <= FETCH.
  - While reset is high, ir_write, pc_write, mem_write, reg_write, instr_done and illegal are forced 0.
  - Mux selects take their FETCH values.
  - Reset mid-instruction aborts the instruction with no partial write.
- Opcodes: lw 0000011, sw 0100011, R 0110011, beq 1100011. Any other opcode is illegal.
- States, with outputs (unlisted outputs are 0 / don't-care 00):
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, alu_op=00, result_src=10, pc_update=1. Goes to DECODE.
  - DECODE: src_a=01, src_b=01, alu_op=00 (branch target). Next state by opcode:
    - lw or sw -> MEM_ADR
    - R -> EXECUTE_R
    - beq -> BEQ
    - other -> FAULT
  - MEM_ADR: src_a=10, src_b=01, alu_op=00. lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ: result_src=00, adr_src=1. Goes to MEM_WB.
  - MEM_WB: result_src=01, reg_write=1, instr_done=1. Goes to FETCH.
  - MEM_WRITE: result_src=00, adr_src=1, mem_write=1, instr_done=1. Goes to FETCH.
  - EXECUTE_R: src_a=10, src_b=00, alu_op=10. Goes to ALU_WB.
  - ALU_WB: result_src=00, reg_write=1, instr_done=1. Goes to FETCH.
  - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1. Goes to FETCH.
  - FAULT: illegal=1. Next state is FAULT if HALT_ON_ILLEGAL=1, else FETCH.
- Latency in cycles: lw 5, sw 4, R 4, beq 3, illegal 3 to FAULT exit (non-halting).
- opcode is sampled only in DECODE and MEM_ADR. Changes in other states are ignored.
- Unreachable state encodings go to FETCH on the next clock, with all enables 0 in that cycle.

Optional Feature:
MEM_WAIT_EN
- When defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEM_READ and MEM_WRITE hold their state while mem_ready=0.
  - ir_write, pc_write and instr_done (MEM_WRITE) are asserted only in the cycle mem_ready=1.
  - mem_write stays high for every cycle spent in MEM_WRITE.
- When undefined: no mem_ready port; behaviour is identical to mem_ready tied to 1.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode localparams
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - src_a, src_b and result_src select encodings
- The ALU-control decoder imports the same ALUOp constants.
- One natural sub-module: mc_state_decode, a purely combinational state -> control-vector decode. The top keeps the state register and next-state logic.

Test Plan:
- Reset held 3 cycles then released with opcode=0110011 -> FETCH (ir_write=1, pc_write=1, alu_src_b=10); then DECODE, EXECUTE_R (alu_op=10), ALU_WB (reg_write=1, instr_done=1). 4 cycles total.
- lw (0000011) -> states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB. adr_src=1 in MEM_READ; result_src=01 and reg_write=1 in MEM_WB. sw (0100011) -> mem_write=1 for exactly one cycle, 4 cycles total.
- beq with zero=1 -> pc_write=1 in BEQ with alu_op=01. Repeat with zero=0 -> pc_write=0. Both return to FETCH.
- opcode=0010011 in DECODE:
  - HALT_ON_ILLEGAL=1 -> illegal=1 held for 10+ cycles, no write enables.
  - HALT_ON_ILLEGAL=0 -> illegal for 1 cycle, then FETCH.
- reset asserted during MEM_WRITE of sw -> mem_write=0 in that cycle; FETCH on the next cycle.
- MEM_WAIT_EN defined, mem_ready=0 for 3 cycles in FETCH -> state held, ir_write=0. Then mem_ready=1 -> ir_write=1 and pc_write=1 for one cycle, then DECODE.
